noise_channel: RTL and testbench

- Parametrised, sequential successor to the combinational noise injector for the Hamming(7,4) link.
- Accepts one codeword per valid/ready handshake, builds an error mask (fixed, random k-bit or random burst) from an internal LFSR, and emits the corrupted word plus the mask.
- Sits between the encoder and the decoder in the bench and FPGA demo; the mask lets the checker score decoder corrections.

---
 rtl/noise_channel.sv | 268 ++++++++++++++++++++++++++
 tb/tb_noise_channel.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noise_channel.sv
// ----------------------------------------------------------------------------
// noise_channel
//   Sequential error injector for the Hamming(7,4) link. It accepts one clean
//   codeword per valid/ready handshake, builds an error mask from an internal
//   Galois LFSR and emits the corrupted word together with the mask so the
//   checker can score the decoder's corrections.
//
//   Modes (cfg_mode, sampled with the word):
//     00  pass-through, mask = 0
//     01  fixed mask    = cfg_mask
//     10  random k-bit  : k = min(cfg_err_num, MAX_ERR) distinct bit positions
//     11  random burst  : min(cfg_err_num, DATA_W) contiguous ones, wrapping
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   in_valid/in_ready     input handshake, in_ready high only when idle
//   in_data               clean codeword
//   cfg_mode/mask/err_num mask configuration, captured on accept
//   out_valid/out_ready   output handshake, outputs held while stalled
//   out_data              in_data ^ out_err_mask
//   out_err_mask          mask applied to the word
//   stat_clr              synchronous clear of the statistics counters
//   stat_words/stat_flips saturating word / flipped-bit counters
//
// Build option
//   NOISE_STATS_EN  when defined the statistics counters are implemented;
//                   otherwise stat_words/stat_flips read 0 and stat_clr is
//                   ignored.
// ----------------------------------------------------------------------------
module noise_channel #(
  parameter int                DATA_W  = 8,
  parameter int                MAX_ERR = 2,
  parameter int                LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED    = LFSR_W'(16'hACE1),
  parameter int                ERR_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        cfg_mode,
  input  logic [DATA_W-1:0] cfg_mask,
  input  logic [ERR_W-1:0]  cfg_err_num,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_err_mask,
  input  logic              stat_clr,
  output logic [15:0]       stat_words,
  output logic [15:0]       stat_flips
);

  localparam int                PW        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int                DW2       = 2 * DATA_W;
  localparam logic [LFSR_W-1:0] TAPS      = LFSR_W'(16'hB400);
  localparam logic [ERR_W-1:0]  MAX_ERR_C = ERR_W'(MAX_ERR);
  localparam logic [ERR_W-1:0]  DATA_W_C  = ERR_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    OUT  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Helper functions
  // --------------------------------------------------------------------------
  // Right-shifting Galois LFSR for x^16+x^14+x^13+x^11+1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [ERR_W-1:0] clamp_cnt(input logic [ERR_W-1:0] n,
                                                 input logic [ERR_W-1:0] lim);
    return (n > lim) ? lim : n;
  endfunction

  // len ones starting at bit start; the run is built in a double-width word
  // and the upper half folded onto the lower half to wrap past bit DATA_W-1.
  function automatic logic [DATA_W-1:0] burst_mask(input logic [PW-1:0]    start,
                                                   input logic [ERR_W-1:0] len);
    logic [DW2-1:0] run;
    run = (DW2'(1) << len) - DW2'(1);
    run = run << start;
    return run[DATA_W-1:0] | run[DW2-1:DATA_W];
  endfunction

  function automatic logic [ERR_W-1:0] popcount(input logic [DATA_W-1:0] m);
    logic [ERR_W-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) begin
      c = c + ERR_W'(m[i]);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q;

  // capture stage: word and working mask while positions are being drawn
  logic [DATA_W-1:0]   data_p0;
  logic [DATA_W-1:0]   mask_p0;
  logic [ERR_W-1:0]    cnt_p0;
  logic [ERR_W-1:0]    hits_p0;

  // output stage: loaded only on entry to OUT so it holds while stalled
  logic [DATA_W-1:0]   data_p1;
  logic [DATA_W-1:0]   mask_p1;

  logic [PW-1:0]       pos;
  logic [DATA_W-1:0]   pos_bit;
  logic                accept;
  logic                go_pick;
  logic                drain;
  logic [ERR_W-1:0]    req_cnt;
  logic [DATA_W-1:0]   direct_mask;
  logic                pos_free;
  logic                pick_done;
  logic [DATA_W-1:0]   pick_mask;

  // --------------------------------------------------------------------------
  // Position draw and mask construction
  // --------------------------------------------------------------------------
  assign pos     = PW'(32'(lfsr_q[7:0]) % 32'(DATA_W));
  assign pos_bit = DATA_W'(1) << pos;

  always_comb begin
    req_cnt     = cfg_err_num;
    direct_mask = '0;
    case (cfg_mode)
      2'b01: direct_mask = cfg_mask;
      2'b10: req_cnt     = clamp_cnt(cfg_err_num, MAX_ERR_C);
      2'b11: begin
        req_cnt     = clamp_cnt(cfg_err_num, DATA_W_C);
        direct_mask = burst_mask(pos, req_cnt);
      end
      default: direct_mask = '0;
    endcase
  end

  assign accept    = (state_q == IDLE) && in_valid;
  assign go_pick   = (cfg_mode == 2'b10) && (req_cnt != '0);
  assign drain     = (state_q == OUT) && out_ready;

  // A drawn position that is already set is simply retried next cycle with
  // the next LFSR value, so the finished mask always has exactly cnt_p0 ones.
  assign pos_free  = ~mask_p0[pos];
  assign pick_mask = mask_p0 | pos_bit;
  assign pick_done = pos_free && ((hits_p0 + ERR_W'(1)) == cnt_p0);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid)  state_d = go_pick ? PICK : OUT;
      PICK: if (pick_done) state_d = OUT;
      OUT:  if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      OUT:     out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Stage p0: capture and random draw (working registers, no reset needed)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p0 <= in_data;
      cnt_p0  <= req_cnt;
      mask_p0 <= '0;
      hits_p0 <= '0;
    end else if ((state_q == PICK) && pos_free) begin
      mask_p0 <= pick_mask;
      hits_p0 <= hits_p0 + ERR_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Stage p1: LFSR and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q  <= SEED;
      data_p1 <= '0;
      mask_p1 <= '0;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
      if (accept && !go_pick) begin
        data_p1 <= in_data ^ direct_mask;
        mask_p1 <= direct_mask;
      end else if ((state_q == PICK) && pick_done) begin
        data_p1 <= data_p0 ^ pick_mask;
        mask_p1 <= pick_mask;
      end
    end
  end

  assign out_data     = data_p1;
  assign out_err_mask = mask_p1;

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef NOISE_STATS_EN
  logic [15:0] words_q;
  logic [15:0] flips_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_q <= '0;
      flips_q <= '0;
    end else if (stat_clr) begin
      words_q <= '0;
      flips_q <= '0;
    end else if (drain) begin
      words_q <= sat_add16(words_q, 16'd1);
      flips_q <= sat_add16(flips_q, 16'(popcount(mask_p1)));
    end
  end

  assign stat_words = words_q;
  assign stat_flips = flips_q;
`else
  logic unused_stat;
  assign unused_stat = stat_clr ^ drain;
  assign stat_words  = '0;
  assign stat_flips  = '0;
`endif

endmodule

// File: tb/tb_noise_channel.sv
module tb_noise_channel;

  localparam int          DATA_W  = 8;
  localparam int          MAX_ERR = 2;
  localparam int          ERR_W   = $clog2(DATA_W + 1);
  localparam logic [15:0] SEED    = 16'hACE1;
`ifdef NOISE_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [1:0]        cfg_mode;
  logic [DATA_W-1:0] cfg_mask;
  logic [ERR_W-1:0]  cfg_err_num;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] out_err_mask;
  logic              stat_clr;
  logic [15:0]       stat_words;
  logic [15:0]       stat_flips;

  int checks = 0;
  int errors = 0;

  noise_channel #(
    .DATA_W (DATA_W),
    .MAX_ERR(MAX_ERR),
    .LFSR_W (16),
    .SEED   (SEED)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .cfg_mode    (cfg_mode),
    .cfg_mask    (cfg_mask),
    .cfg_err_num (cfg_err_num),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_err_mask(out_err_mask),
    .stat_clr    (stat_clr),
    .stat_words  (stat_words),
    .stat_flips  (stat_flips)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    bit          init;
    bit          busy;
    bit          valid;
    int          wait_n;
    int          words;
    int          flips;
    logic [15:0] lfsr;
    logic [7:0]  pend_d;
    logic [7:0]  pend_m;
    logic [7:0]  d;
    logic [7:0]  m;
  } mstate_t;

  mstate_t ms = '0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic int clampi(input int n, input int lim);
    return (n > lim) ? lim : n;
  endfunction

  // On accept the whole mask and the number of draw cycles are worked out
  // by walking the LFSR sequence forward; afterwards the model only counts.
  function automatic mstate_t model_step(input mstate_t s, input logic rn, input logic iv,
                                         input logic [1:0] md, input logic [7:0] id,
                                         input logic [7:0] cm, input logic [3:0] en,
                                         input logic ordy, input logic sclr);
    mstate_t     n = s;
    int          p;
    int          cnt;
    int          steps;
    logic [15:0] l;
    logic [7:0]  mk;
    if (!rn) begin
      n      = '0;
      n.init = 1'b1;
      n.lfsr = SEED;
      return n;
    end
    if (s.valid && ordy) begin
      n.busy  = 1'b0;
      n.valid = 1'b0;
    end else if (!s.busy && iv) begin
      p     = int'(s.lfsr[7:0]) % DATA_W;
      mk    = '0;
      steps = 0;
      case (md)
        2'b01: mk = cm;
        2'b10: begin
          cnt = clampi(int'(en), MAX_ERR);
          l   = s.lfsr;
          while ($countones(mk) < cnt && steps < 10000) begin
            l = lfsr_next(l);
            steps++;
            mk[int'(l[7:0]) % DATA_W] = 1'b1;
          end
        end
        2'b11: begin
          cnt = clampi(int'(en), DATA_W);
          for (int i = 0; i < cnt; i++) mk[(p + i) % DATA_W] = 1'b1;
        end
        default: mk = '0;
      endcase
      n.busy   = 1'b1;
      n.pend_d = id ^ mk;
      n.pend_m = mk;
      if (steps == 0) begin
        n.valid = 1'b1;
        n.d     = id ^ mk;
        n.m     = mk;
      end else begin
        n.wait_n = steps;
      end
    end else if (s.busy && !s.valid) begin
      n.wait_n = s.wait_n - 1;
      if (n.wait_n == 0) begin
        n.valid = 1'b1;
        n.d     = s.pend_d;
        n.m     = s.pend_m;
      end
    end
    if (sclr) begin
      n.words = 0;
      n.flips = 0;
    end else if (s.valid && ordy) begin
      n.words = (s.words + 1 > 65535) ? 65535 : s.words + 1;
      n.flips = (s.flips + $countones(s.m) > 65535) ? 65535 : s.flips + $countones(s.m);
    end
    n.lfsr = lfsr_next(s.lfsr);
    return n;
  endfunction

  always @(posedge clk) begin
    ms <= model_step(ms, rst_n, in_valid, cfg_mode, in_data, cfg_mask, cfg_err_num,
                     out_ready, stat_clr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (ms.init) begin
      check("in_ready",     32'(in_ready),     32'(!ms.busy));
      check("out_valid",    32'(out_valid),    32'(ms.valid));
      check("out_data",     32'(out_data),     32'(ms.d));
      check("out_err_mask", 32'(out_err_mask), 32'(ms.m));
      check("stat_words",   32'(stat_words),   STATS_ON ? 32'(ms.words) : 32'd0);
      check("stat_flips",   32'(stat_flips),   STATS_ON ? 32'(ms.flips) : 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] mode, input logic [7:0] data,
                      input logic [7:0] msk, input logic [3:0] num);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    cfg_mode    = mode;
    in_data     = data;
    cfg_mask    = msk;
    cfg_err_num = num;
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid    = 1'b0;
    // scramble configuration; the word already accepted must ignore it
    cfg_mode    = 2'($urandom);
    cfg_mask    = 8'($urandom);
    cfg_err_num = 4'($urandom);
    in_data     = 8'($urandom);
  endtask

  task automatic wait_out(output logic [7:0] d, output logic [7:0] m);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    d = out_data;
    m = out_err_mask;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
  endtask

  function automatic bit is_burst3(input logic [7:0] m);
    logic [15:0] t;
    for (int s = 0; s < 8; s++) begin
      t = 16'h0007 << s;
      if ((t[7:0] | t[15:8]) == m) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  d;
    logic [7:0]  m;
    logic [7:0]  x;
    logic [15:0] f0;
    logic [7:0]  run1[$];

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    cfg_mode    = '0;
    cfg_mask    = '0;
    cfg_err_num = '0;
    out_ready   = 1'b1;
    stat_clr    = 1'b0;
    @(negedge clk);
    @(negedge clk);

    check("rst_out_valid", 32'(out_valid),    32'd0);
    check("rst_out_data",  32'(out_data),     32'd0);
    check("rst_out_mask",  32'(out_err_mask), 32'd0);
    check("rst_in_ready",  32'(in_ready),     32'd1);
    check("rst_words",     32'(stat_words),   32'd0);
    check("rst_flips",     32'(stat_flips),   32'd0);

    // burst on the first cycle after reset: LFSR=ACE1, pos=0xE1%8=1
    rst_n = 1'b1;
    send(2'b11, 8'h00, 8'h00, 4'd3);
    check("burst_latency", 32'(out_valid), 32'd1);
    wait_out(d, m);
    check("burst_seed_mask", 32'(m), 32'h0E);
    check("burst_seed_data", 32'(d), 32'h0E);

    // one random error after reset: draw uses E270, pos=0x70%8=0
    do_reset();
    send(2'b10, 8'hF0, 8'h00, 4'd1);
    check("pick_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("pick_latency", 32'(out_valid), 32'd1);
    wait_out(d, m);
    check("pick_seed_mask", 32'(m), 32'h01);
    check("pick_seed_data", 32'(d), 32'hF1);

    // pass-through
    send(2'b00, 8'hA5, 8'hFF, 4'd7);
    check("pass_latency", 32'(out_valid), 32'd1);
    wait_out(d, m);
    check("pass_data", 32'(d), 32'hA5);
    check("pass_mask", 32'(m), 32'h00);

    // fixed mask, flip counter grows by two
    send(2'b01, 8'h0F, 8'h81, 4'd0);
    f0 = stat_flips;
    wait_out(d, m);
    check("fixed_data", 32'(d), 32'h8E);
    check("fixed_mask", 32'(m), 32'h81);
    @(negedge clk);
`ifdef NOISE_STATS_EN
    check("fixed_flips_delta", 32'(stat_flips), 32'(f0 + 16'd2));
`endif

    // output stall for five cycles
    out_ready = 1'b0;
    send(2'b01, 8'h3C, 8'h24, 4'd0);
    wait_out(d, m);
    check("stall_data", 32'(d), 32'h18);
    check("stall_mask", 32'(m), 32'h24);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid",    32'(out_valid),    32'd1);
      check("stall_hold_d",   32'(out_data),     32'h18);
      check("stall_hold_m",   32'(out_err_mask), 32'h24);
      check("stall_in_ready", 32'(in_ready),     32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_valid",    32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready),  32'd1);

    // error count above MAX_ERR is clamped
    send(2'b10, 8'h00, 8'h00, 4'd5);
    wait_out(d, m);
    check("clamp_popcount", 32'($countones(m)), 32'd2);

    // reset while drawing positions discards the word
    send(2'b10, 8'h55, 8'h00, 4'd2);
    check("pick_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("pickrst_valid",    32'(out_valid),  32'd0);
    check("pickrst_in_ready", 32'(in_ready),   32'd1);
    check("pickrst_words",    32'(stat_words), 32'd0);
    check("pickrst_flips",    32'(stat_flips), 32'd0);
    rst_n = 1'b1;

    // identical stimulus after reset yields the identical mask sequence
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int i = 0; i < 20; i++) begin
        send(2'b10, 8'(i), 8'h00, 4'd2);
        wait_out(d, m);
        if (r == 0) run1.push_back(m);
        else        check("replay_mask", 32'(m), 32'(run1[i]));
      end
    end

    // random k-bit, 1000 words
    for (int i = 0; i < 1000; i++) begin
      x = 8'($urandom);
      send(2'b10, x, 8'($urandom), (i % 10 == 0) ? 4'd5 : 4'd2);
      wait_out(d, m);
      check("k_popcount", 32'($countones(m)), 32'd2);
      check("k_data",     32'(d),             32'(x ^ m));
    end

    // random burst, 500 words
    for (int i = 0; i < 500; i++) begin
      x = 8'($urandom);
      send(2'b11, x, 8'($urandom), 4'd3);
      wait_out(d, m);
      check("burst_shape", 32'(is_burst3(m)), 32'd1);
      check("burst_data",  32'(d),            32'(x ^ m));
    end

    // fully random traffic with backpressure, clears and occasional reset
    for (int c = 0; c < 4000; c++) begin
      rst_n       = ($urandom_range(199) != 0);
      in_valid    = 1'($urandom_range(1));
      cfg_mode    = 2'($urandom);
      in_data     = 8'($urandom);
      cfg_mask    = 8'($urandom);
      cfg_err_num = 4'($urandom);
      out_ready   = ($urandom_range(3) != 0);
      stat_clr    = ($urandom_range(49) == 0);
      @(negedge clk);
    end
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stat_clr  = 1'b0;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
